apb_mem_slave: RTL and testbench

//   Parametrised APB4 completer exposing a DEPTH-word register memory.

---
 rtl/apb_mem_pkg.sv | 19 +
 rtl/apb_mem_array.sv | 40 ++++
 rtl/apb_mem_slave.sv | 124 ++++++++++++
 tb/tb_apb_mem_slave.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB memory completer.
// Used by apb_mem_slave and apb_mem_array.
package apb_mem_pkg;

    typedef enum logic {IDLE, ACCESS} apb_mem_state_t;

    localparam int MAX_WAIT = 15;

    // Byte-offset bits below the word index.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Bits needed to index the word array.
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_WIDTH register storage for the APB memory completer.
// Async reset to zero, byte-enable write port, combinational read port.
module apb_mem_array
    import apb_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int NB        = DATA_WIDTH / 8,
    localparam int IW        = idx_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [IW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [NB-1:0]         wstrb_i,
    input  logic [IW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Clear on reset; update only the strobed bytes of the addressed word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 completer with a DEPTH-word memory, byte strobes and wait states.
// Optional macro APB_MEM_WR_PROTECT_EN adds pprot write protection.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
`ifdef APB_MEM_WR_PROTECT_EN
    input  logic [2:0]              pprot,
`endif
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int AL   = addr_lsb(DATA_WIDTH);
    localparam int IW   = idx_width(DEPTH);
    localparam int WS_C = (WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES;
    localparam logic [3:0] WAIT_INIT = 4'(WS_C);

    apb_mem_state_t        state_q;
    logic [3:0]            wcnt_q;
    logic [IW-1:0]         idx_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NB-1:0]         strb_q;
    logic                  err_q;

    logic                  misaligned;
    logic                  out_of_range;
    logic                  rd_strb_err;
    logic                  prot_err;
    logic                  setup_err;
    logic                  complete;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Error decode on the live bus; only sampled in the setup cycle.
    assign misaligned   = |(paddr & ADDR_WIDTH'(NB - 1));
    assign out_of_range = |(paddr >> (AL + IW));
    assign rd_strb_err  = ~pwrite & (|pstrb);

`ifdef APB_MEM_WR_PROTECT_EN
    logic unused_prot;
    assign unused_prot = ^pprot[2:1];
    // Unprivileged writes may not touch the upper half of the memory.
    assign prot_err = pwrite & ~pprot[0] & paddr[AL + IW - 1];
`else
    assign prot_err = 1'b0;
`endif

    assign setup_err = misaligned | out_of_range | rd_strb_err | prot_err;

    // Transfer FSM: latch the request at setup, count waits, then complete.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (psel && !penable) begin
                        state_q <= ACCESS;
                        wcnt_q  <= WAIT_INIT;
                        idx_q   <= paddr[AL +: IW];
                        wr_q    <= pwrite;
                        wdata_q <= pwdata;
                        strb_q  <= pstrb;
                        err_q   <= setup_err;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state_q <= IDLE;
                    end else if (wcnt_q != 4'd0) begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end else if (penable) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // An aborted access (psel dropped) never reports ready.
    assign pready   = (state_q == ACCESS) & (wcnt_q == 4'd0) & psel;
    assign complete = pready & penable;
    assign pslverr  = pready & err_q;
    assign prdata   = (pready & ~wr_q & ~err_q) ? mem_rdata : '0;
    assign mem_we   = complete & wr_q & ~err_q;

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk_i   (pclk),
        .rst_ni  (presetn),
        .we_i    (mem_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .wstrb_i (strb_q),
        .raddr_i (idx_q),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: two instances (0 and 3 wait states),
// checked every cycle against a word-array model of the memory.
module tb_apb_mem_slave;
    import apb_mem_pkg::*;

    logic        clk = 1'b0;
    logic        presetn = 1'b0;
    logic        psel0 = 1'b0;
    logic        psel1 = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;

    logic [31:0] prdata0;
    logic        pready0;
    logic        pslverr0;
    logic [31:0] prdata1;
    logic        pready1;
    logic        pslverr1;

    int total = 0;
    int bad = 0;

    logic [31:0] m [2][16];
    int          k [2];
    int          wsv [2] = '{0, 3};
    logic        exp_err [2];
    logic [31:0] exp_rd [2];
    logic [31:0] last_rd [2];
    logic        last_err [2];

    always #5 clk = ~clk;

    apb_mem_slave #(.WAIT_STATES(0)) u0 (
        .pclk    (clk),
        .presetn (presetn),
        .psel    (psel0),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
`ifdef APB_MEM_WR_PROTECT_EN
        .pprot   (pprot),
`endif
        .prdata  (prdata0),
        .pready  (pready0),
        .pslverr (pslverr0)
    );

    apb_mem_slave #(.WAIT_STATES(3)) u1 (
        .pclk    (clk),
        .presetn (presetn),
        .psel    (psel1),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
`ifdef APB_MEM_WR_PROTECT_EN
        .pprot   (pprot),
`endif
        .prdata  (prdata1),
        .pready  (pready1),
        .pslverr (pslverr1)
    );

    task automatic cmp(input string n, input int d,
                       input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d: got=%h want=%h", n, d, got, want);
        end
    endtask

    // Expected outputs: ready exactly on access cycle W, zero elsewhere.
    task automatic chk(input int d, input logic sel, input logic rdy,
                       input logic slv, input logic [31:0] rd);
        logic er;
        if (presetn && sel && penable) begin
            er = (k[d] == wsv[d]);
            k[d]++;
        end else begin
            er = 1'b0;
            k[d] = 0;
        end
        cmp("pready", d, {31'b0, rdy}, {31'b0, er});
        cmp("pslverr", d, {31'b0, slv}, {31'b0, er & exp_err[d]});
        if (er && !pwrite) begin
            cmp("prdata", d, rd, exp_rd[d]);
            last_rd[d] = rd;
            last_err[d] = slv;
        end else if (!er) begin
            cmp("prdata_idle", d, rd, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        chk(0, psel0, pready0, pslverr0, prdata0);
        chk(1, psel1, pready1, pslverr1, prdata1);
    end

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                m[d][i] = '0;
    endtask

    // One APB transfer; bus is scrambled after setup to prove latching.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [2:0] pr);
        int idx;
        bit e;
        idx = int'((a >> 2) & 32'hF);
        e = (a[1:0] != 2'b0) || (a >= 32'd64) || (!wr && st != 4'h0);
`ifdef APB_MEM_WR_PROTECT_EN
        if (wr && !pr[0] && idx >= 8) e = 1'b1;
`endif
        @(posedge clk);
        #1;
        psel0 = (d == 0);
        psel1 = (d == 1);
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = wd;
        pstrb = st;
        pprot = pr;
        exp_err[d] = e;
        exp_rd[d] = e ? 32'h0 : m[d][idx];
        @(posedge clk);
        #1;
        penable = 1'b1;
        paddr = a ^ 32'h4;
        pwdata = ~wd;
        pstrb = wr ? ~st : st;
        repeat (wsv[d]) @(posedge clk);
        @(posedge clk);
        if (wr && !e)
            for (int b = 0; b < 4; b++)
                if (st[b]) m[d][idx][8*b +: 8] = wd[8*b +: 8];
        #1;
        psel0 = 1'b0;
        psel1 = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        model_clear();
        for (int d = 0; d < 2; d++) begin
            k[d] = 0;
            exp_err[d] = 1'b0;
            exp_rd[d] = '0;
            last_rd[d] = '0;
            last_err[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        presetn = 1'b1;

        // Basic write/read, zero wait states.
        xfer(0, 1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001);
        xfer(0, 0, 32'h04, 32'h0, 4'h0, 3'b001);
        cmp("lit_deadbeef", 0, last_rd[0], 32'hDEADBEEF);

        // Byte strobes merge into the existing word.
        xfer(0, 1, 32'h08, 32'h11223344, 4'hF, 3'b001);
        xfer(0, 1, 32'h08, 32'hAABBCCDD, 4'h5, 3'b001);
        xfer(0, 0, 32'h08, 32'h0, 4'h0, 3'b001);
        cmp("lit_strb", 0, last_rd[0], 32'h11BB33DD);

        // Three wait states, plus a zero-strobe write that must be a no-op.
        xfer(1, 1, 32'h10, 32'hCAFEF00D, 4'hF, 3'b001);
        xfer(1, 1, 32'h10, 32'h12345678, 4'h0, 3'b001);
        xfer(1, 0, 32'h10, 32'h0, 4'h0, 3'b001);
        cmp("lit_wait", 1, last_rd[1], 32'hCAFEF00D);
        xfer(1, 0, 32'h3C, 32'h0, 4'h0, 3'b001);

        // Error cases leave memory untouched.
        xfer(0, 0, 32'h40, 32'h0, 4'h0, 3'b001);
        cmp("lit_oor_err", 0, {31'b0, last_err[0]}, 32'h1);
        xfer(0, 1, 32'h06, 32'h99999999, 4'hF, 3'b001);
        xfer(0, 0, 32'h04, 32'h0, 4'h1, 3'b001);
        cmp("lit_rdstrb_err", 0, {31'b0, last_err[0]}, 32'h1);
        xfer(0, 1, 32'h44, 32'h77777777, 4'hF, 3'b001);
        xfer(0, 0, 32'h04, 32'h0, 4'h0, 3'b001);
        cmp("lit_unchanged", 0, last_rd[0], 32'hDEADBEEF);

`ifdef APB_MEM_WR_PROTECT_EN
        // Unprivileged upper-half write is rejected; privileged succeeds.
        xfer(0, 1, 32'h3C, 32'h5A5A5A5A, 4'hF, 3'b000);
        xfer(0, 0, 32'h3C, 32'h0, 4'h0, 3'b000);
        cmp("lit_prot_blk", 0, last_rd[0], 32'h0);
        xfer(0, 1, 32'h3C, 32'h5A5A5A5A, 4'hF, 3'b001);
        xfer(0, 0, 32'h3C, 32'h0, 4'h0, 3'b000);
        cmp("lit_prot_ok", 0, last_rd[0], 32'h5A5A5A5A);
`endif

        // Reset in the middle of an access aborts the write.
        @(posedge clk);
        #1;
        psel0 = 1'b1;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h0C;
        pwdata = 32'h55AA55AA;
        pstrb = 4'hF;
        exp_err[0] = 1'b0;
        @(posedge clk);
        #1;
        penable = 1'b1;
        #1;
        presetn = 1'b0;
        #1;
        cmp("rst_state", 0, {31'b0, u0.state_q}, {31'b0, IDLE});
        cmp("rst_pready", 0, {31'b0, pready0}, 32'h0);
        model_clear();
        @(posedge clk);
        #1;
        psel0 = 1'b0;
        penable = 1'b0;
        presetn = 1'b1;
        xfer(0, 0, 32'h0C, 32'h0, 4'h0, 3'b001);
        cmp("lit_rst_rd", 0, last_rd[0], 32'h0);
        xfer(0, 0, 32'h04, 32'h0, 4'h0, 3'b001);
        cmp("lit_rst_clr", 0, last_rd[0], 32'h0);

        // Back-to-back transfers on the slow instance after reset.
        xfer(1, 1, 32'h00, 32'h01020304, 4'hF, 3'b001);
        xfer(1, 1, 32'h00, 32'hF0F0F0F0, 4'hA, 3'b001);
        xfer(1, 0, 32'h00, 32'h0, 4'h0, 3'b001);
        cmp("lit_b2b", 1, last_rd[1], 32'hF002F004);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
